fir_tap_buffer: RTL and testbench

Sample delay line and tap sequencer feeding the serial FIR MAC of each equalizer band. It accepts one audio sample per sample strobe, stores it in a circular buffer of TAPS entries, and streams taps x[n-0] … x[n-(TAPS-1)] on consecutive enabled clocks. Tap index and first/last markers are aligned to the filter's 0..TAPS-1 phase count. It is the producer side of the filter's per-phase tap interface; the filter consumes one tap per enabled cycle.

---
 rtl/fir_tap_buffer.sv | 130 +++++++++++++
 tb/tb_fir_tap_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_buffer.sv
// Circular sample delay line that streams x[n-0] .. x[n-(TAPS-1)] to a serial FIR MAC.
// Optional build macro FIR_TAP_ZERO_FILL_EN: taps beyond the written history read as zero.
module fir_tap_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int TAPS       = 64,
    parameter int IDX_WIDTH  = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clk_enable,
    input  logic signed [DATA_WIDTH-1:0] sample_in,
    input  logic                         sample_valid,
    output logic signed [DATA_WIDTH-1:0] tap_data,
    output logic        [IDX_WIDTH-1:0]  tap_index,
    output logic                         tap_valid,
    output logic                         tap_first,
    output logic                         tap_last,
    output logic                         busy,
    output logic                         overrun
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    localparam logic [IDX_WIDTH-1:0] K_LAST = IDX_WIDTH'(TAPS - 1);

    state_t                         state_q;
    logic signed [DATA_WIDTH-1:0]   mem_q [TAPS];
    logic        [IDX_WIDTH-1:0]    wr_ptr_q;
    logic        [IDX_WIDTH-1:0]    base_q;
    logic        [IDX_WIDTH-1:0]    k_q;
    logic signed [DATA_WIDTH-1:0]   tap_data_q;
    logic                           tap_valid_q;
    logic                           tap_first_q;
    logic                           tap_last_q;
    logic                           overrun_q;

    logic                           accept_d;
    logic        [IDX_WIDTH-1:0]    k_d;
    logic        [IDX_WIDTH-1:0]    rd_addr_d;
    logic signed [DATA_WIDTH-1:0]   rd_data_d;
    logic                           hist_ok_d;

    // Tap 0 is taken straight from sample_in, so reads only ever target k>=1 and never
    // collide with the slot being written in the same cycle.
    always_comb begin
        accept_d  = clk_enable && sample_valid && ((state_q == IDLE) || tap_last_q);
        k_d       = k_q + IDX_WIDTH'(1);
        rd_addr_d = base_q - k_d;
        rd_data_d = mem_q[rd_addr_d];
    end

`ifdef FIR_TAP_ZERO_FILL_EN
    localparam logic [IDX_WIDTH:0] FILL_MAX = (IDX_WIDTH + 1)'(TAPS);

    logic [IDX_WIDTH:0] fill_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q <= '0;
        end else if (accept_d && (fill_q != FILL_MAX)) begin
            fill_q <= fill_q + (IDX_WIDTH + 1)'(1);
        end
    end

    assign hist_ok_d = ({1'b0, k_d} < fill_q);
`else
    assign hist_ok_d = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (accept_d && !rst) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            base_q      <= '0;
            k_q         <= '0;
            tap_data_q  <= '0;
            tap_valid_q <= 1'b0;
            tap_first_q <= 1'b0;
            tap_last_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (clk_enable) begin
            if (accept_d) begin
                state_q     <= STREAM;
                base_q      <= wr_ptr_q;
                wr_ptr_q    <= wr_ptr_q + IDX_WIDTH'(1);
                k_q         <= '0;
                tap_data_q  <= sample_in;
                tap_valid_q <= 1'b1;
                tap_first_q <= 1'b1;
                tap_last_q  <= 1'b0;
            end else if (state_q == STREAM) begin
                // Not accepted while streaming: a strobe here can only mean tap_last is low.
                if (sample_valid) begin
                    overrun_q <= 1'b1;
                end
                if (tap_last_q) begin
                    state_q     <= IDLE;
                    k_q         <= '0;
                    tap_data_q  <= '0;
                    tap_valid_q <= 1'b0;
                    tap_first_q <= 1'b0;
                    tap_last_q  <= 1'b0;
                end else begin
                    k_q         <= k_d;
                    tap_data_q  <= hist_ok_d ? rd_data_d : '0;
                    tap_first_q <= 1'b0;
                    tap_last_q  <= (k_d == K_LAST);
                end
            end
        end
    end

    assign tap_data  = tap_data_q;
    assign tap_index = k_q;
    assign tap_valid = tap_valid_q;
    assign tap_first = tap_first_q;
    assign tap_last  = tap_last_q;
    assign busy      = tap_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_fir_tap_buffer.sv
// Scoreboard bench for fir_tap_buffer: a history-queue model predicts every tap stream,
// and a monitor compares each presented tap as it appears.
module tb_fir_tap_buffer;

    localparam int DW   = 16;
    localparam int TAPS = 64;
    localparam int IW   = 6;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 clk_enable = 1'b0;
    logic signed [DW-1:0] sample_in = '0;
    logic                 sample_valid = 1'b0;
    logic signed [DW-1:0] tap_data;
    logic        [IW-1:0] tap_index;
    logic                 tap_valid, tap_first, tap_last, busy, overrun;

    fir_tap_buffer #(
        .DATA_WIDTH(DW),
        .TAPS      (TAPS),
        .IDX_WIDTH (IW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_enable  (clk_enable),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .tap_data    (tap_data),
        .tap_index   (tap_index),
        .tap_valid   (tap_valid),
        .tap_first   (tap_first),
        .tap_last    (tap_last),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          k;
        logic [DW-1:0] data;
        bit          first;
        bit          last;
        bit          chk;
    } tap_t;

    int            checks = 0;
    int            errors = 0;
    tap_t          sbq[$];
    logic [DW-1:0] hist[$];
    int            m_k   = -1;
    bit            m_ovr = 1'b0;

    task automatic model_reset();
        sbq.delete();
        hist.delete();
        m_k   = -1;
        m_ovr = 1'b0;
    endtask

    // Reference: the stream for a new sample is x[n-k] drawn from the history of
    // samples accepted since reset; older slots are either zero or unknown.
    task automatic model_step(input bit sv, input logic [DW-1:0] d);
        bit   acc;
        tap_t it;
        acc = sv && (m_k < 0 || m_k == TAPS - 1);
        if (sv && !acc) m_ovr = 1'b1;
        if (acc) begin
            hist.push_back(d);
            if (hist.size() > TAPS) void'(hist.pop_front());
            for (int k = 0; k < TAPS; k++) begin
                it.k     = k;
                it.first = (k == 0);
                it.last  = (k == TAPS - 1);
                if (k < hist.size()) begin
                    it.data = hist[hist.size() - 1 - k];
                    it.chk  = 1'b1;
                end else begin
`ifdef FIR_TAP_ZERO_FILL_EN
                    it.data = '0;
                    it.chk  = 1'b1;
`else
                    it.data = '0;
                    it.chk  = 1'b0;
`endif
                end
                sbq.push_back(it);
            end
            m_k = 0;
        end else if (m_k >= 0) begin
            m_k = (m_k == TAPS - 1) ? -1 : m_k + 1;
        end
    endtask

    task automatic drive(input bit r, input bit en, input bit sv, input logic [DW-1:0] d);
        @(negedge clk);
        rst          = r;
        clk_enable   = en;
        sample_valid = sv;
        sample_in    = d;
        @(posedge clk);
        if (r) model_reset();
        else if (en) model_step(sv, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!(m_k < 0 || m_k == TAPS - 1) && guard < 200) begin
            drive(1'b0, 1'b1, 1'b0, '0);
            guard++;
        end
    endtask

    task automatic wait_k(input int k);
        int guard = 0;
        while (m_k != k && guard < 200) begin
            drive(1'b0, 1'b1, 1'b0, '0);
            guard++;
        end
    endtask

    // Monitor: pops one expected tap per enabled edge, checks hold on stalled edges.
    initial begin : monitor
        bit   r_s, e_s, held_v;
        tap_t exp_t, held;
        held_v = 1'b0;
        forever begin
            @(posedge clk);
            r_s = rst;
            e_s = clk_enable;
            #1;
            checks++;
            if (r_s) begin
                held_v = 1'b0;
                if (tap_valid !== 1'b0 || busy !== 1'b0 || tap_first !== 1'b0 || tap_last !== 1'b0 ||
                    tap_index !== '0 || tap_data !== '0) begin
                    errors++;
                    $display("FAIL reset_outputs: got v=%b b=%b f=%b l=%b idx=%0d data=%h, want all 0",
                             tap_valid, busy, tap_first, tap_last, tap_index, tap_data);
                end
            end else begin
                if (e_s) begin
                    if (sbq.size() > 0) begin
                        held   = sbq.pop_front();
                        held_v = 1'b1;
                    end else begin
                        held_v = 1'b0;
                    end
                end
                exp_t = held;
                if (held_v) begin
                    if (tap_valid !== 1'b1 || busy !== 1'b1 || tap_index !== IW'(exp_t.k) ||
                        tap_first !== exp_t.first || tap_last !== exp_t.last ||
                        (exp_t.chk && tap_data !== exp_t.data)) begin
                        errors++;
                        $display("FAIL tap(en=%b): got v=%b b=%b idx=%0d data=%h f=%b l=%b, want v=1 b=1 idx=%0d data=%h f=%b l=%b",
                                 e_s, tap_valid, busy, tap_index, tap_data, tap_first, tap_last,
                                 exp_t.k, exp_t.data, exp_t.first, exp_t.last);
                    end
                end else if (tap_valid !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_valid(en=%b): got v=%b b=%b idx=%0d, want v=0 b=0",
                             e_s, tap_valid, busy, tap_index);
                end
            end
            checks++;
            if (overrun !== m_ovr) begin
                errors++;
                $display("FAIL overrun: got %b, want %b", overrun, m_ovr);
            end
        end
    end

    initial begin : stimulus
        drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b1, 1'b1, 16'h1234);

        // Single sample, zero history behind it.
        drive(1'b0, 1'b1, 1'b1, 16'h1000);
        idle(70);

        // 70 back-to-back samples, each strobe coincident with the previous tap_last.
        drive(1'b1, 1'b1, 1'b0, '0);
        for (int v = 1; v <= 70; v++) begin
            wait_ready();
            drive(1'b0, 1'b1, 1'b1, DW'(v));
        end
        idle(70);

        // Dropped strobe mid-stream; overrun stays sticky afterwards.
        wait_ready();
        drive(1'b0, 1'b1, 1'b1, DW'($urandom));
        wait_k(10);
        drive(1'b0, 1'b1, 1'b1, 16'hDEAD);
        idle(70);

        // Enable toggling during a stream, with strobes on stalled cycles ignored.
        drive(1'b0, 1'b1, 1'b1, DW'($urandom));
        for (int i = 0; i < 140; i++)
            drive(1'b0, (i % 2) == 0, (i % 2) == 1, DW'($urandom));
        idle(10);

        // Reset mid-stream, then a fresh stream starts from empty history.
        drive(1'b0, 1'b1, 1'b1, DW'($urandom));
        wait_k(30);
        drive(1'b1, 1'b1, 1'b0, '0);
        drive(1'b0, 1'b1, 1'b1, 16'h7FFF);
        idle(70);

        // 65 increasing samples: write pointer wraps, oldest sample falls out.
        drive(1'b1, 1'b0, 1'b0, '0);
        for (int v = 0; v < 65; v++) begin
            wait_ready();
            drive(1'b0, 1'b1, 1'b1, DW'(16'h0100 + v));
        end
        idle(70);

        // Random enables, strobes and data.
        for (int i = 0; i < 3000; i++)
            drive(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, DW'($urandom));

        for (int i = 0; i < 300 && (sbq.size() > 0 || m_k >= 0); i++)
            drive(1'b0, 1'b1, 1'b0, '0);
        idle(2);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d taps still expected, want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
